// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin arbiter that shares one UART TX byte interface among N_REQ
// requesters. A grant lasts for a whole packet, which ends on the grantee's
// last byte or after MAX_BURST bytes, whichever comes first. GAP_CYC idle
// cycles follow every packet before the next arbitration.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-requester byte valid
//   i_req_data   flattened bytes, requester k at [k*DATA_W +: DATA_W]
//   i_req_last   per-requester last-byte flag (qualified by valid)
//   o_req_ready  per-requester byte accept (only the grantee can be high)
//   o_tx_valid   byte valid to the UART TX serializer
//   o_tx_data    byte to the UART TX serializer (0 when not valid)
//   i_tx_ready   serializer can accept a byte
//   o_grant_id   index of the current or most recent grantee
//   o_busy       high whenever the arbiter is not idle

module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]  i_req_data,
    input  logic [N_REQ-1:0]         i_req_last,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_tx_valid,
    output logic [DATA_W-1:0]        o_tx_data,
    input  logic                     i_tx_ready,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_busy
);

    localparam int unsigned GntW = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [GntW-1:0] LastId   = GntW'(N_REQ - 1);
    localparam logic [CntW-1:0] BurstEnd = CntW'(MAX_BURST - 1);
    // Unused when GAP_CYC == 0 because the gap state is never entered.
    localparam logic [GapW-1:0] GapEnd   = GapW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [1:0] {
        ArbIdle,
        ArbXfer,
        ArbGap
    } arb_state_e;

    arb_state_e      state_q, state_d;
    logic [GntW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GntW-1:0] grant_id_q, grant_id_d;
    logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

    // Signals of the current grantee.
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;

    // Round-robin pick: the lowest valid index at or above rr_ptr wins,
    // otherwise the scan wraps to the lowest valid index overall.
    logic            hi_found;
    logic            lo_found;
    logic [GntW-1:0] hi_pick;
    logic [GntW-1:0] lo_pick;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (GntW'(k) == grant_id_q) begin
                sel_valid = i_req_valid[k];
                sel_last  = i_req_last[k];
                sel_data  = i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        // Downward scan so the last hit is the lowest index.
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (i_req_valid[k]) begin
                lo_found = 1'b1;
                lo_pick  = GntW'(k);
                if (GntW'(k) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_pick  = GntW'(k);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        o_req_ready = '0;
        o_tx_valid  = 1'b0;
        o_tx_data   = '0;

        case (state_q)
            ArbIdle: begin
                if (lo_found) begin
                    grant_id_d = hi_found ? hi_pick : lo_pick;
                    byte_cnt_d = '0;
                    state_d    = ArbXfer;
                end
            end

            ArbXfer: begin
                o_tx_valid = sel_valid;
                o_tx_data  = sel_valid ? sel_data : '0;
                for (int k = 0; k < int'(N_REQ); k++) begin
                    o_req_ready[k] = (GntW'(k) == grant_id_q) && i_tx_ready;
                end
                if (sel_valid && i_tx_ready) begin
                    byte_cnt_d = byte_cnt_q + CntW'(1);
                    // A burst cut leaves the rest of the packet queued at the
                    // requester; it competes again as a fresh packet.
                    if (sel_last || (byte_cnt_q == BurstEnd)) begin
                        rr_ptr_d  = (grant_id_q == LastId) ? '0 : grant_id_q + GntW'(1);
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYC > 0) ? ArbGap : ArbIdle;
                    end
                end
            end

            ArbGap: begin
                if (gap_cnt_q == GapEnd) begin
                    gap_cnt_d = '0;
                    state_d   = ArbIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end

            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ArbIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign o_grant_id = grant_id_q;
    assign o_busy     = (state_q != ArbIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a packet-level reference model.

module tb_uart_tx_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;
    localparam int GAP_CYC   = 2;
    localparam int GNT_W     = $clog2(N_REQ);
    localparam int DEPTH     = 8192;

    logic                    i_clk = 1'b0;
    logic                    i_rst_n = 1'b0;
    logic [N_REQ-1:0]        i_req_valid;
    logic [N_REQ*DATA_W-1:0] i_req_data;
    logic [N_REQ-1:0]        i_req_last;
    logic [N_REQ-1:0]        o_req_ready;
    logic                    o_tx_valid;
    logic [DATA_W-1:0]       o_tx_data;
    logic                    i_tx_ready;
    logic [GNT_W-1:0]        o_grant_id;
    logic                    o_busy;

    uart_tx_arbiter #(
        .N_REQ    (N_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req_valid(i_req_valid),
        .i_req_data (i_req_data),
        .i_req_last (i_req_last),
        .o_req_ready(o_req_ready),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready),
        .o_grant_id (o_grant_id),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    // Requester byte sources: {last, data} per entry.
    bit [8:0]         mem [N_REQ][DEPTH];
    int               rd [N_REQ];
    int               wr [N_REQ];
    logic [N_REQ-1:0] en;
    logic [N_REQ-1:0] hs = '0;
    int               cyc = 0;

    // Log of bytes accepted by the serializer.
    int log_data[$];
    int log_gid[$];
    int log_cyc[$];

    // Reference model: who owns the link, bytes sent in this grant,
    // remaining gap cycles, last grantee, next scan start.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_dead  = 0;
    int m_gid   = 0;
    int m_rr    = 0;

    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    logic [N_REQ-1:0]  e_ready;
    logic              e_busy;
    int                pick;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lgd(input int i);
        return (i < log_data.size()) ? log_data[i] : -1;
    endfunction

    function automatic int lgg(input int i);
        return (i < log_gid.size()) ? log_gid[i] : -1;
    endfunction

    function automatic int lgc(input int i);
        return (i < log_cyc.size()) ? log_cyc[i] : -1;
    endfunction

    // Compare process: outputs are stable at the falling edge.
    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst_n) begin
            m_owner = -1;
            m_cnt   = 0;
            m_dead  = 0;
            m_gid   = 0;
            m_rr    = 0;
            e_valid = 1'b0;
            e_data  = '0;
            e_ready = '0;
            e_busy  = 1'b0;
        end else begin
            e_busy  = (m_owner >= 0) || (m_dead > 0);
            e_valid = 1'b0;
            e_data  = '0;
            e_ready = '0;
            if (m_owner >= 0) begin
                e_valid = i_req_valid[m_owner];
                e_data  = e_valid ? i_req_data[m_owner*DATA_W +: DATA_W] : '0;
                e_ready[m_owner] = i_tx_ready;
            end
        end
        chk("tx_valid", 64'(o_tx_valid), 64'(e_valid));
        chk("tx_data", 64'(o_tx_data), 64'(e_data));
        chk("req_ready", 64'(o_req_ready), 64'(e_ready));
        chk("grant_id", 64'(o_grant_id), 64'(m_gid));
        chk("busy", 64'(o_busy), 64'(e_busy));

        hs = o_req_ready & i_req_valid;
        if (i_rst_n && o_tx_valid && i_tx_ready) begin
            log_data.push_back(int'(o_tx_data));
            log_gid.push_back(int'(o_grant_id));
            log_cyc.push_back(cyc);
        end

        if (i_rst_n) begin
            if (m_owner >= 0) begin
                if (i_req_valid[m_owner] && i_tx_ready) begin
                    m_cnt++;
                    if (i_req_last[m_owner] || m_cnt == MAX_BURST) begin
                        m_rr    = (m_owner + 1) % N_REQ;
                        m_owner = -1;
                        m_dead  = GAP_CYC;
                    end
                end
            end else if (m_dead > 0) begin
                m_dead--;
            end else begin
                pick = -1;
                for (int i = 0; i < N_REQ; i++) begin
                    if (pick < 0 && i_req_valid[(m_rr + i) % N_REQ]) pick = (m_rr + i) % N_REQ;
                end
                if (pick >= 0) begin
                    m_owner = pick;
                    m_gid   = pick;
                    m_cnt   = 0;
                end
            end
        end
    end

    task automatic drive();
        for (int k = 0; k < N_REQ; k++) begin
            if (en[k] && rd[k] < wr[k]) begin
                i_req_valid[k] = 1'b1;
                i_req_last[k]  = mem[k][rd[k]][8];
                i_req_data[k*DATA_W +: DATA_W] = mem[k][rd[k]][7:0];
            end else begin
                i_req_valid[k] = 1'b0;
                i_req_last[k]  = 1'($urandom);
                i_req_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        for (int k = 0; k < N_REQ; k++) if (hs[k]) rd[k]++;
        drive();
    endtask

    task automatic push_pkt(input int k, input int len, input int base, input bit with_last);
        for (int j = 0; j < len; j++) begin
            mem[k][wr[k]] = {with_last && (j == len - 1), 8'(base + j)};
            wr[k]++;
        end
    endtask

    task automatic clear_srcs();
        for (int k = 0; k < N_REQ; k++) begin
            rd[k] = 0;
            wr[k] = 0;
        end
    endtask

    task automatic clear_log();
        log_data.delete();
        log_gid.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        step();
        i_rst_n    = 1'b0;
        clear_srcs();
        en         = '1;
        i_tx_ready = 1'b1;
        step();
        step();
        i_rst_n = 1'b1;
        clear_log();
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (log_data.size() < n && t < budget) begin
            step();
            t++;
        end
        chk(name, 64'(log_data.size() >= n), 64'd1);
    endtask

    int v_cyc;

    initial begin
        clear_srcs();
        en         = '0;
        i_tx_ready = 1'b0;
        drive();
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_tx_valid", 64'(o_tx_valid), 64'd0);
        chk("reset_grant", 64'(o_grant_id), 64'd0);

        // Single requester, three-byte packet.
        do_reset();
        push_pkt(1, 3, 'h41, 1'b1);
        step();
        v_cyc = cyc;
        run_until(3, 20, "t1_done");
        repeat (4) step();
        chk("t1_count", 64'(log_data.size()), 64'd3);
        chk("t1_b0", 64'(lgd(0)), 64'h41);
        chk("t1_b1", 64'(lgd(1)), 64'h42);
        chk("t1_b2", 64'(lgd(2)), 64'h43);
        chk("t1_gid", 64'(lgg(2)), 64'd1);
        chk("t1_latency", 64'(lgc(0) - v_cyc), 64'd2);
        chk("t1_back2back", 64'(lgc(2) - lgc(0)), 64'd2);

        // Everyone requesting single-byte packets: strict rotation.
        do_reset();
        for (int k = 0; k < N_REQ; k++) begin
            push_pkt(k, 1, 'h10 * k, 1'b1);
            push_pkt(k, 1, 'h10 * k + 1, 1'b1);
        end
        run_until(5, 60, "t2_done");
        for (int i = 0; i < 5; i++) chk("t2_order", 64'(lgg(i)), 64'(i % 4));
        for (int i = 0; i < 4; i++) chk("t2_spacing", 64'(lgc(i + 1) - lgc(i)), 64'd4);
        chk("t2_wrap_data", 64'(lgd(4)), 64'h01);

        // Backpressure toggling during a four-byte packet.
        do_reset();
        push_pkt(2, 4, 'hC1, 1'b1);
        for (int t = 0; t < 40 && log_data.size() < 4; t++) begin
            step();
            i_tx_ready = ~i_tx_ready;
        end
        i_tx_ready = 1'b1;
        repeat (6) step();
        chk("t3_count", 64'(log_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t3_data", 64'(lgd(i)), 64'('hC1 + i));

        // Burst truncation at MAX_BURST with a competing requester.
        do_reset();
        push_pkt(0, 20, 0, 1'b1);
        push_pkt(3, 3, 'h30, 1'b1);
        run_until(23, 200, "t4_done");
        repeat (4) step();
        chk("t4_count", 64'(log_data.size()), 64'd23);
        chk("t4_b15_gid", 64'(lgg(15)), 64'd0);
        chk("t4_b15_data", 64'(lgd(15)), 64'd15);
        chk("t4_r3_first", 64'(lgg(16)), 64'd3);
        chk("t4_r3_data", 64'(lgd(16)), 64'h30);
        chk("t4_r3_last", 64'(lgg(18)), 64'd3);
        chk("t4_resume_gid", 64'(lgg(19)), 64'd0);
        chk("t4_resume_data", 64'(lgd(19)), 64'd16);
        chk("t4_final_data", 64'(lgd(22)), 64'd19);

        // Reset mid-packet clears the round-robin pointer.
        do_reset();
        push_pkt(2, 1, 'h22, 1'b1);
        run_until(1, 20, "t5_pre");
        repeat (4) step();
        push_pkt(1, 5, 'h51, 1'b1);
        run_until(3, 30, "t5_two_bytes");
        chk("t5_mid_valid", 64'(o_tx_valid), 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 64'(o_tx_valid), 64'd0);
        chk("t5_async_data", 64'(o_tx_data), 64'd0);
        chk("t5_async_ready", 64'(o_req_ready), 64'd0);
        chk("t5_async_grant", 64'(o_grant_id), 64'd0);
        chk("t5_async_busy", 64'(o_busy), 64'd0);
        clear_srcs();
        step();
        step();
        push_pkt(1, 2, 'h61, 1'b1);
        push_pkt(3, 2, 'h71, 1'b1);
        clear_log();
        i_rst_n = 1'b1;
        run_until(4, 40, "t5_after");
        chk("t5_first_gid", 64'(lgg(0)), 64'd1);
        chk("t5_first_data", 64'(lgd(0)), 64'h61);
        chk("t5_second_gid", 64'(lgg(2)), 64'd3);

        // Grantee stalls mid-packet; grant is held.
        do_reset();
        en = 4'b0100;
        push_pkt(2, 4, 'h81, 1'b1);
        push_pkt(0, 2, 'h91, 1'b1);
        run_until(1, 20, "t6_start");
        en = 4'b0001;
        repeat (10) step();
        chk("t6_stall_hold", 64'(log_data.size()), 64'd2);
        chk("t6_stall_grant", 64'(o_grant_id), 64'd2);
        en = 4'b0101;
        run_until(6, 60, "t6_done");
        chk("t6_r2_last_gid", 64'(lgg(3)), 64'd2);
        chk("t6_r2_last_data", 64'(lgd(3)), 64'h84);
        chk("t6_r0_after", 64'(lgg(4)), 64'd0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            step();
            i_tx_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N_REQ; k++) begin
                en[k] = ($urandom_range(0, 7) != 0);
                if (rd[k] == wr[k] && wr[k] < DEPTH - 32 && $urandom_range(0, 3) == 0)
                    push_pkt(k, $urandom_range(1, 20), $urandom, 1'b1);
            end
            i_rst_n = ($urandom_range(0, 999) != 0);
        end
        i_rst_n = 1'b1;
        repeat (2) step();
        chk("rand_progress", 64'(log_data.size() > 300), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
